// File: rtl/enc4to2_hs_if.sv
// enc4to2_hs_if: request/code/handshake bundle between a requester and the encoder
interface enc4to2_hs_if;
    logic [3:0] d;
    logic       ack;
    logic [1:0] b;
    logic       valid;
    logic       multi;

    modport master (output d, output ack, input b, input valid, input multi);
    modport slave  (input d, input ack, output b, output valid, output multi);
endinterface

// File: rtl/enc4to2_hs.sv
// enc4to2_hs: qualified, registered 4-to-2 priority encoder with valid/ack hold; ENC_MULTI_ERR_EN enables the multi-line flag
module enc4to2_hs #(
    parameter int STABLE_CYCLES = 4
) (
    input logic         clk,
    input logic         rst_n,
    enc4to2_hs_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD, RELEASE} state_t;

    localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

    state_t     state_q;
    logic [3:0] snap_q;
    logic [7:0] cnt_q;
    logic [1:0] b_q;
    logic       valid_q;
    logic       multi_q;
    logic [1:0] code_d;
    logic       multi_d;
    logic [7:0] cnt_d;

    // Encode the live request: an issue only happens when d equals the snapshot
    always_comb begin
        code_d = bus.d[3] ? 2'd3 : bus.d[2] ? 2'd2 : bus.d[1] ? 2'd1 : 2'd0;
`ifdef ENC_MULTI_ERR_EN
        multi_d = |(bus.d & (bus.d - 4'd1));
`else
        multi_d = 1'b0;
`endif
        cnt_d = cnt_q + 8'd1;
    end

    // Qualify, issue, hold until ack, then wait for all lines to release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            snap_q  <= 4'd0;
            cnt_q   <= 8'd0;
            b_q     <= 2'd0;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.d != 4'd0) begin
                        snap_q <= bus.d;
                        cnt_q  <= 8'd1;
                        if (STABLE_N == 8'd1) begin
                            state_q <= HOLD;
                            b_q     <= code_d;
                            valid_q <= 1'b1;
                            multi_q <= multi_d;
                        end else begin
                            state_q <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (bus.d == 4'd0) begin
                        state_q <= IDLE;
                        cnt_q   <= 8'd0;
                    end else if (bus.d != snap_q) begin
                        snap_q <= bus.d;
                        cnt_q  <= 8'd1;
                    end else begin
                        cnt_q <= cnt_d;
                        if (cnt_d == STABLE_N) begin
                            state_q <= HOLD;
                            b_q     <= code_d;
                            valid_q <= 1'b1;
                            multi_q <= multi_d;
                        end
                    end
                end
                HOLD: begin
                    if (bus.ack) begin
                        state_q <= RELEASE;
                        valid_q <= 1'b0;
                        multi_q <= 1'b0;
                    end
                end
                RELEASE: begin
                    if (bus.d == 4'd0) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.b     = b_q;
    assign bus.valid = valid_q;
    assign bus.multi = multi_q;
endmodule
